// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage with optional skid entry, flush/hold and bubble fill; 1-cycle latency.
// SKID=1 registers ready_o (no ready_i -> ready_o path); SKID=0 passes ready_i through combinationally.
module pipe_stage_hs #(
  parameter int unsigned       DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter bit                SKID   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic [1:0]        count_o
);

  logic              out_v_q, out_v_d;
  logic              sk_v_q, sk_v_d;
  logic [DATA_W-1:0] out_d_q, out_d_d;
  logic [DATA_W-1:0] sk_d_q, sk_d_d;
  logic              can_move;
  logic              accept;
  logic              emit;

  always_comb begin
    can_move = ~hold_i & ~flush_i & ~rst_i;
    if (SKID) begin
      ready_o = ~sk_v_q & can_move;
    end else begin
      ready_o = (~out_v_q | ready_i) & can_move;
    end
    valid_o = out_v_q & ~hold_i;
    data_o  = out_d_q;
    count_o = {1'b0, out_v_q} + {1'b0, sk_v_q};
    accept  = valid_i & ready_o;
    emit    = valid_o & ready_i;
  end

  always_comb begin
    out_v_d = out_v_q;
    out_d_d = out_d_q;
    sk_v_d  = sk_v_q;
    sk_d_d  = sk_d_q;
    // Flush wins over hold; reset is applied in the register process.
    if (flush_i) begin
      out_v_d = 1'b0;
      out_d_d = BUBBLE;
      sk_v_d  = 1'b0;
    end else if (!hold_i) begin
      if (!out_v_q || emit) begin
        if (sk_v_q) begin
          out_v_d = 1'b1;
          out_d_d = sk_d_q;
          sk_v_d  = accept;
          if (accept) begin
            sk_d_d = data_i;
          end
        end else if (accept) begin
          out_v_d = 1'b1;
          out_d_d = data_i;
        end else begin
          out_v_d = 1'b0;
          out_d_d = BUBBLE;
        end
      end else if (accept) begin
        // Output still occupied: the new payload queues behind it.
        sk_v_d = 1'b1;
        sk_d_d = data_i;
      end
    end
    if (!SKID) begin
      sk_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_v_q <= 1'b0;
      out_d_q <= BUBBLE;
      sk_v_q  <= 1'b0;
      sk_d_q  <= BUBBLE;
    end else begin
      out_v_q <= out_v_d;
      out_d_q <= out_d_d;
      sk_v_q  <= sk_v_d;
      sk_d_q  <= sk_d_d;
    end
  end

endmodule
